alu_seq_core: RTL and testbench

Parametrised, handshaked successor to the single-shot ALU: one datapath, WIDTH-bit operands, 2*WIDTH-bit result Z.
Logic, shift and add ops complete in one cycle. Multiply is an iterative radix-2 Booth sequencer and divide is an iterative non-restoring signed divider, both multi-cycle.
Sits between the register file (A, B operands) and the Z register, and is driven by the control unit through a start/done handshake.

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_seq_core_div.sv | 24 ++
 rtl/alu_seq_core.sv | 192 +++++++++++++++++++
 tb/tb_alu_seq_core.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encoding and helpers for alu_seq_core.
// Imported by the top and the divider step.
package alu_seq_pkg;

  localparam logic [4:0] OP_SHL = 5'h01;
  localparam logic [4:0] OP_SHR = 5'h02;
  localparam logic [4:0] OP_SRA = 5'h03;
  localparam logic [4:0] OP_ROL = 5'h04;
  localparam logic [4:0] OP_ROR = 5'h05;
  localparam logic [4:0] OP_AND = 5'h06;
  localparam logic [4:0] OP_OR  = 5'h07;
  localparam logic [4:0] OP_NOT = 5'h08;
  localparam logic [4:0] OP_NEG = 5'h09;
  localparam logic [4:0] OP_ADD = 5'h0A;
  localparam logic [4:0] OP_SUB = 5'h0B;
  localparam logic [4:0] OP_MUL = 5'h0C;
  localparam logic [4:0] OP_DIV = 5'h0D;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  function automatic logic is_multicycle(
    input logic [4:0] op
  );
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_core_div.sv
// One non-restoring division iteration on magnitudes.
// rem/quo in, shifted and corrected rem_nxt/quo_nxt out.
module nonrestoring_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] shl;

  assign shl = {rem[WIDTH-1:0], quo[WIDTH-1]};

  // A negative partial remainder is repaired by adding
  // back instead of restoring in place.
  assign rem_nxt = rem[WIDTH] ? shl + {1'b0, dvs}
                              : shl - {1'b0, dvs};

  assign quo_nxt = {quo[WIDTH-2:0], ~rem_nxt[WIDTH]};

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked ALU: 1-cycle logic/shift/add, Booth MUL, NR DIV.
// start/op/a/b in; busy/done/z/div_by_zero/illegal_op out.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z,
  output logic               div_by_zero,
  output logic               illegal_op
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t state;
  state_t state_nxt;

  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] lo;
  logic             qm1;

  logic             accept;
  logic             legal;
  logic             div0;
  logic             div_run;
  logic             last;
  logic [SHW-1:0]   sh;
  logic [SHW:0]     shc;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] d_mag;
  logic [WIDTH:0]   bh;
  logic [WIDTH:0]   bk_hi;
  logic [WIDTH-1:0] bk_lo;
  logic             bk_qm1;
  logic [WIDTH:0]   dv_hi;
  logic [WIDTH-1:0] dv_lo;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign accept  = (state == S_IDLE) && start;
  assign legal   = (op >= OP_SHL) && (op <= OP_DIV);
  assign div0    = (op == OP_DIV) && (b == '0);
  assign div_run = (op == OP_DIV) && (b != '0);
  assign last    = (cnt == CW'(1));
  assign sh      = b[SHW-1:0];
  assign shc     = (SHW+1)'(WIDTH) - {1'b0, sh};
  assign busy    = (state == S_ITER) || (state == S_FIX);
  assign done    = (state == S_DONE);

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign d_mag = b_q[WIDTH-1] ? -b_q : b_q;

  always_comb begin
    sc_res = '0;
    unique case (op)
      OP_SHL:  sc_res = a << sh;
      OP_SHR:  sc_res = a >> sh;
      OP_SRA:  sc_res = $signed(a) >>> sh;
      // shc = WIDTH when sh = 0, which shifts out to zero
      OP_ROL:  sc_res = (a << sh) | (a >> shc);
      OP_ROR:  sc_res = (a >> sh) | (a << shc);
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_NOT:  sc_res = ~a;
      OP_NEG:  sc_res = -a;
      OP_ADD:  sc_res = a + b;
      OP_SUB:  sc_res = a - b;
      default: sc_res = '0;
    endcase
  end

  // hi carries one guard bit so -min multiplicand
  // cannot overflow the partial product.
  always_comb begin
    bh = hi;
    unique case ({lo[0], qm1})
      2'b01:   bh = hi + {a_q[WIDTH-1], a_q};
      2'b10:   bh = hi - {a_q[WIDTH-1], a_q};
      default: bh = hi;
    endcase
    {bk_hi, bk_lo, bk_qm1} = {bh[WIDTH], bh, lo};
  end

  nonrestoring_div_step #(
    .WIDTH(WIDTH)
  ) u_div (
    .rem     (hi),
    .quo     (lo),
    .dvs     (d_mag),
    .rem_nxt (dv_hi),
    .quo_nxt (dv_lo)
  );

  assign rem_mag = hi[WIDTH] ? hi[WIDTH-1:0] + d_mag
                             : hi[WIDTH-1:0];
  assign q_fix = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -lo : lo;
  assign r_fix = a_q[WIDTH-1] ? -rem_mag : rem_mag;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (legal && is_multicycle(op) && !div0)
            state_nxt = S_ITER;
          else
            state_nxt = S_DONE;
        end
      end
      S_ITER: begin
        if (last)
          state_nxt = (op_q == OP_DIV) ? S_FIX : S_DONE;
      end
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      qm1         <= 1'b0;
      z           <= '0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      if (accept) begin
        op_q        <= op;
        a_q         <= a;
        b_q         <= b;
        cnt         <= CW'(WIDTH);
        hi          <= '0;
        qm1         <= 1'b0;
        div_by_zero <= 1'b0;
        illegal_op  <= 1'b0;
        unique case (1'b1)
          !legal: begin
            z          <= '0;
            illegal_op <= 1'b1;
          end
          div0: begin
            z           <= {a, {WIDTH{1'b1}}};
            div_by_zero <= 1'b1;
          end
          (op == OP_MUL): lo <= b;
          div_run:        lo <= a_mag;
          default: z <= {{WIDTH{1'b0}}, sc_res};
        endcase
      end
      if (state == S_ITER) begin
        cnt <= cnt - CW'(1);
        if (op_q == OP_MUL) begin
          hi  <= bk_hi;
          lo  <= bk_lo;
          qm1 <= bk_qm1;
          if (last) z <= {bk_hi[WIDTH-1:0], bk_lo};
        end else begin
          hi <= dv_hi;
          lo <= dv_lo;
        end
      end
      if (state == S_FIX) z <= {r_fix, q_fix};
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed + random bench for alu_seq_core, WIDTH=32.
// Expected results queued on drive, popped on done.
module tb_alu_seq_core;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [4:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [2*W-1:0] z;
  logic          dbz;
  logic          ill;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] z;
    logic        dbz;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .z           (z),
    .div_by_zero (dbz),
    .illegal_op  (ill)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] expv
  );
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(
    input logic [63:0] zz,
    input logic        d,
    input logic        i,
    input int          l
  );
    exp_t e;
    e.z = zz;
    e.dbz = d;
    e.ill = i;
    e.lat = l;
    return e;
  endfunction

  function automatic exp_t model(
    input logic [4:0]  o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    exp_t e;
    int s;
    logic [31:0] r;
    logic signed [31:0] sx, sy;
    logic signed [63:0] px, py;
    e = mk(64'h0, 1'b0, 1'b0, 1);
    s = int'(y[4:0]);
    sx = x;
    sy = y;
    r = '0;
    case (o)
      5'h01: r = x << s;
      5'h02: r = x >> s;
      5'h03: r = sx >>> s;
      5'h04: r = (s == 0) ? x : (x << s) | (x >> (32 - s));
      5'h05: r = (s == 0) ? x : (x >> s) | (x << (32 - s));
      5'h06: r = x & y;
      5'h07: r = x | y;
      5'h08: r = ~x;
      5'h09: r = -x;
      5'h0A: r = x + y;
      5'h0B: r = x - y;
      default: r = '0;
    endcase
    e.z = {32'h0, r};
    if (o == 5'h0C) begin
      px = sx;
      py = sy;
      e.z = px * py;
      e.lat = 33;
    end else if (o == 5'h0D) begin
      if (y == 0) begin
        e.z = {x, 32'hFFFFFFFF};
        e.dbz = 1'b1;
      end else begin
        e.lat = 34;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF)
          e.z = {32'h0, x};
        else
          e.z = {32'(sx % sy), 32'(sx / sy)};
      end
    end else if (o == 5'h00 || o > 5'h0D) begin
      e.z = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // Drive one op; optionally poke an ADD start while busy.
  task automatic do_op(
    input string       tag,
    input logic [4:0]  o,
    input logic [31:0] x,
    input logic [31:0] y,
    input exp_t        e,
    input int          poke
  );
    int n;
    int bcnt;
    exp_t g;
    @(negedge clk);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    bcnt = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (busy) bcnt++;
      if (n == poke) begin
        op = 5'h0A;
        a = 32'd100;
        b = 32'd200;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    g = sb.pop_front();
    check({tag, "/lat"}, 64'(n), 64'(g.lat));
    check({tag, "/busy"}, 64'(bcnt), 64'(g.lat - 1));
    check({tag, "/z"}, z, g.z);
    check({tag, "/dbz"}, 64'(dbz), 64'(g.dbz));
    check({tag, "/ill"}, 64'(ill), 64'(g.ill));
  endtask

  initial begin
    int dcnt;
    logic [4:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1;
    start = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/busy", 64'(busy), 64'(0));
    check("rst/done", 64'(done), 64'(0));
    check("rst/z", z, 64'(0));
    check("rst/dbz", 64'(dbz), 64'(0));
    check("rst/ill", 64'(ill), 64'(0));
    reset = 1'b0;

    do_op("sra", 5'h03, 32'h80000000, 32'd4,
          mk(64'h00000000_F8000000, 0, 0, 1), 0);
    do_op("ror", 5'h05, 32'h00000001, 32'd1,
          mk(64'h00000000_80000000, 0, 0, 1), 0);
    do_op("mul", 5'h0C, 32'hFFFFFFFD, 32'd7,
          mk(64'hFFFFFFFF_FFFFFFEB, 0, 0, 33), 0);
    do_op("div", 5'h0D, 32'hFFFFFFF9, 32'd2,
          mk(64'hFFFFFFFF_FFFFFFFD, 0, 0, 34), 0);
    do_op("divmin", 5'h0D, 32'h80000000, 32'hFFFFFFFF,
          mk(64'h00000000_80000000, 0, 0, 34), 0);
    do_op("div0", 5'h0D, 32'h00001234, 32'd0,
          mk(64'h00001234_FFFFFFFF, 1, 0, 1), 0);
    do_op("ill", 5'h1F, 32'h12345678, 32'h9,
          mk(64'h0, 0, 1, 1), 0);
    do_op("mulpoke", 5'h0C, 32'd5, 32'd6,
          mk(64'd30, 0, 0, 33), 10);
    do_op("b2b", 5'h0A, 32'd1, 32'd2,
          mk(64'd3, 0, 0, 1), 0);

    @(negedge clk);
    op = 5'h0C;
    a = 32'd9;
    b = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort/busy", 64'(busy), 64'(0));
    check("abort/z", z, 64'(0));
    check("abort/done", 64'(done), 64'(0));
    reset = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort/nodone", 64'(dcnt), 64'(0));
    do_op("wrap", 5'h0A, 32'hFFFFFFFF, 32'd1,
          mk(64'h0, 0, 0, 1), 0);

    do_op("shl0", 5'h01, 32'hA5A5A5A5, 32'h20,
          model(5'h01, 32'hA5A5A5A5, 32'h20), 0);
    do_op("rol0", 5'h04, 32'h8000_0001, 32'd0,
          model(5'h04, 32'h8000_0001, 32'd0), 0);
    do_op("rol31", 5'h04, 32'h8000_0003, 32'd31,
          model(5'h04, 32'h8000_0003, 32'd31), 0);
    do_op("negmin", 5'h09, 32'h80000000, 32'd0,
          model(5'h09, 32'h80000000, 32'd0), 0);
    do_op("mulmin", 5'h0C, 32'h80000000, 32'h80000000,
          model(5'h0C, 32'h80000000, 32'h80000000), 0);
    do_op("divneg", 5'h0D, 32'd100, 32'hFFFFFFF9,
          model(5'h0D, 32'd100, 32'hFFFFFFF9), 0);
    do_op("op00", 5'h00, 32'd1, 32'd1,
          model(5'h00, 32'd1, 32'd1), 0);

    for (int i = 0; i < 24; i++) begin
      ro = 5'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 5) rb = '0;
      do_op($sformatf("rnd%0d_op%0h", i, ro), ro, ra, rb,
            model(ro, ra, rb), 0);
    end

    check("sb/empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
